// File: rtl/sram_banked_1rw.sv
// Banked single-port RW memory with a valid/ready request port, 1- or 2-cycle read
// latency, per-bit write mask and an optional post-reset fill of every word.
module sram_banked_1rw #(
  parameter int              BITS          = 32,
  parameter int              WORD_DEPTH    = 1024,
  parameter int              ADDR_WIDTH    = $clog2(WORD_DEPTH),
  parameter int              NUM_BANKS     = 4,
  parameter int              OUT_REG       = 0,
  parameter int              INIT_ON_RESET = 1,
  parameter logic [BITS-1:0] INIT_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  we_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic                  rsp_valid_out,
  output logic [BITS-1:0]       rd_out,
  output logic                  init_done_out
);

  localparam int SHIFT  = $clog2(NUM_BANKS);
  localparam int BANK_W = (NUM_BANKS > 1) ? SHIFT : 1;
  localparam int ROWS   = WORD_DEPTH / NUM_BANKS;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0] row;
  logic             fill, accept, wr_en, rd_en;
  logic             v1_q;
  logic [BITS-1:0]  rd1_q;
  logic [BITS-1:0]  mem_q [NUM_BANKS][ROWS];

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign bank = addr_in[BANK_W-1:0];
  end else begin : g_single_bank
    assign bank = '0;
  end
  assign row = ROW_W'(addr_in >> SHIFT);

  assign fill          = (state_q == ST_INIT);
  assign req_ready_out = (state_q == ST_READY);
  assign init_done_out = (state_q == ST_READY);
  assign accept        = req_valid_in && req_ready_out && !reset;
  assign wr_en         = accept && we_in;
  assign rd_en         = accept && !we_in;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ROW_W'(ROWS - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fill writes one row across all banks; a request only enables its own bank.
  always_ff @(posedge clk) begin
    // NOTE: storage is intentionally not reset; contents come from the fill or from writes.
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (fill) begin
          mem_q[b][cnt_q] <= INIT_VALUE;
        end else if (wr_en && (bank == BANK_W'(b))) begin
          mem_q[b][row] <= (mem_q[b][row] & ~w_mask_in) | (wd_in & w_mask_in);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      rd1_q <= '0;
    end else begin
      v1_q <= rd_en;
      if (rd_en) rd1_q <= mem_q[bank][row];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic            v2_q;
    logic [BITS-1:0] rd2_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q  <= 1'b0;
        rd2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) rd2_q <= rd1_q;
      end
    end
    assign rsp_valid_out = v2_q;
    assign rd_out        = rd2_q;
  end else begin : g_no_out_reg
    assign rsp_valid_out = v1_q;
    assign rd_out        = rd1_q;
  end

endmodule

// File: tb/tb_sram_banked_1rw.sv
// Bench for sram_banked_1rw: three configurations share one request stream and are
// compared every cycle against a word-array model with a queue of scheduled responses.
`timescale 1ns/1ps
module tb_sram_banked_1rw;

  localparam int NC = 3;
  localparam logic [31:0] IV = 32'hA5A5_A5A5;
  localparam int DEPTH [NC] = '{1024, 256, 1024};
  localparam int ROWS  [NC] = '{256, 128, 1024};
  localparam int OUTR  [NC] = '{0, 1, 1};

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          we = 1'b0;
  logic [9:0]    addr = '0;
  logic [31:0]   wd = '0;
  logic [31:0]   wm = '0;
  logic [NC-1:0] ready, rvalid, done;
  logic [31:0]   rd [NC];

  logic [31:0] mem_m [NC][1024];
  rsp_t        rq [NC][$];
  logic [31:0] held [NC];
  int cyc = 0;
  int lre = -100000;
  int zero_at = -1;
  int mon_start = 1 << 30;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_banked_1rw #(.BITS(32), .WORD_DEPTH(1024), .ADDR_WIDTH(10), .NUM_BANKS(4),
                    .OUT_REG(0), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid_in(req_valid), .req_ready_out(ready[0]),
    .addr_in(addr), .we_in(we), .wd_in(wd), .w_mask_in(wm),
    .rsp_valid_out(rvalid[0]), .rd_out(rd[0]), .init_done_out(done[0]));

  sram_banked_1rw #(.BITS(32), .WORD_DEPTH(256), .ADDR_WIDTH(8), .NUM_BANKS(2),
                    .OUT_REG(1), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid_in(req_valid), .req_ready_out(ready[1]),
    .addr_in(addr[7:0]), .we_in(we), .wd_in(wd), .w_mask_in(wm),
    .rsp_valid_out(rvalid[1]), .rd_out(rd[1]), .init_done_out(done[1]));

  sram_banked_1rw #(.BITS(32), .WORD_DEPTH(1024), .ADDR_WIDTH(10), .NUM_BANKS(1),
                    .OUT_REG(1), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid_in(req_valid), .req_ready_out(ready[2]),
    .addr_in(addr), .we_in(we), .wd_in(wd), .w_mask_in(wm),
    .rsp_valid_out(rvalid[2]), .rd_out(rd[2]), .init_done_out(done[2]));

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle monitor: ready/done follow the fill length, responses pop in order.
  always @(posedge clk) begin
    #1;
    if (cyc >= mon_start) begin
      for (int k = 0; k < NC; k++) begin
        logic exp_rdy;
        logic exp_v;
        exp_rdy = (cyc >= lre + ROWS[k]);
        if (cyc == zero_at) held[k] = '0;
        exp_v = (rq[k].size() > 0) && (rq[k][0].due == cyc);
        if (exp_v) begin
          held[k] = rq[k][0].data;
          void'(rq[k].pop_front());
        end
        checks += 4;
        if (ready[k] !== exp_rdy) begin
          errors++;
          $display("FAIL mon_ready cfg%0d cyc %0d got %b exp %b", k, cyc, ready[k], exp_rdy);
        end
        if (done[k] !== exp_rdy) begin
          errors++;
          $display("FAIL mon_done cfg%0d cyc %0d got %b exp %b", k, cyc, done[k], exp_rdy);
        end
        if (rvalid[k] !== exp_v) begin
          errors++;
          $display("FAIL mon_rsp_valid cfg%0d cyc %0d got %b exp %b", k, cyc, rvalid[k], exp_v);
        end
        if (rd[k] !== held[k]) begin
          errors++;
          $display("FAIL mon_rd cfg%0d cyc %0d got %h exp %h", k, cyc, rd[k], held[k]);
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit v, input logic [9:0] a, input bit w,
                       input logic [31:0] d, input logic [31:0] m);
    @(negedge clk);
    reset = rst; req_valid = v; addr = a; we = w; wd = d; wm = m;
    if (rst) begin
      if (mon_start > cyc + 1) mon_start = cyc + 1;
      lre = cyc + 1;
      zero_at = cyc + 1;
      for (int k = 0; k < NC; k++) begin
        while (rq[k].size() > 0 && rq[k][$].due > cyc) void'(rq[k].pop_back());
        for (int i = 0; i < 1024; i++) mem_m[k][i] = IV;
      end
    end else if (v) begin
      for (int k = 0; k < NC; k++) begin
        if (cyc >= lre + ROWS[k]) begin
          int ak;
          ak = int'(a) % DEPTH[k];
          if (w) mem_m[k][ak] = (mem_m[k][ak] & ~m) | (d & m);
          else rq[k].push_back('{due: cyc + 1 + OUTR[k], data: mem_m[k][ak]});
        end
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [31:0] m);
    drive(1'b0, 1'b1, a, 1'b1, d, m);
  endtask

  task automatic rdq(input logic [9:0] a);
    drive(1'b0, 1'b1, a, 1'b0, '0, '0);
  endtask

  task automatic wait_all_done();
    for (int i = 0; i < 3000; i++) begin
      idle();
      if (&done) break;
    end
    checks++;
    if (!(&done)) begin
      errors++;
      $display("FAIL wait_all_done timeout got %b exp 111", done);
    end
  endtask

  task automatic test_reset();
    int t [NC];
    int r;
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    r = lre;
    for (int k = 0; k < NC; k++) t[k] = -1;
    // Reads offered during the fill must be ignored.
    for (int i = 0; i < 1500; i++) begin
      rdq(10'($urandom));
      for (int k = 0; k < NC; k++) if (done[k] && t[k] < 0) t[k] = cyc;
      if (&done) break;
    end
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (t[k] - r != ROWS[k]) begin
        errors++;
        $display("FAIL init_len cfg%0d got %0d exp %0d", k, t[k] - r, ROWS[k]);
      end
    end
    for (int a = 0; a < 1024; a++) rdq(10'(a));
    repeat (3) idle();
    checks++;
    if (rd[0] !== IV) begin
      errors++;
      $display("FAIL init_value got %h exp %h", rd[0], IV);
    end
  endtask

  task automatic test_masked_write();
    wr(10'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    wr(10'd5, 32'h0000_1234, 32'h0000_FFFF);
    rdq(10'd5);
    idle();
    checks += 3;
    if (rvalid[0] !== 1'b1 || rd[0] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL mask_lat1 got v=%b d=%h exp v=1 d=dead1234", rvalid[0], rd[0]);
    end
    if (rvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL mask_lat2_early got %b exp 0", rvalid[1]);
    end
    if (rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL mask_lat2_early1bank got %b exp 0", rvalid[2]);
    end
    idle();
    checks += 3;
    if (rvalid[1] !== 1'b1 || rd[1] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL mask_lat2 got v=%b d=%h exp v=1 d=dead1234", rvalid[1], rd[1]);
    end
    if (rvalid[0] !== 1'b0 || rd[0] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL mask_hold got v=%b d=%h exp v=0 d=dead1234", rvalid[0], rd[0]);
    end
    if (rvalid[2] !== 1'b1 || rd[2] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL mask_lat2_1bank got v=%b d=%h exp v=1 d=dead1234", rvalid[2], rd[2]);
    end
    wr(10'd6, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr(10'(i), 32'h100 + i, 32'hFFFF_FFFF);
    rdq(10'd0);
    for (int i = 1; i < 4; i++) begin
      rdq(10'(i));
      checks++;
      if (rvalid[0] !== 1'b1 || rd[0] !== 32'h100 + i - 1) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b d=%h exp v=1 d=%h", i - 1, rvalid[0], rd[0], 32'h100 + i - 1);
      end
    end
    idle();
    checks++;
    if (rvalid[0] !== 1'b1 || rd[0] !== 32'h103) begin
      errors++;
      $display("FAIL b2b_3 got v=%b d=%h exp v=1 d=103", rvalid[0], rd[0]);
    end
    idle();
    checks++;
    if (rvalid[0] !== 1'b0 || rd[0] !== 32'h103 || rd[1] !== 32'h103) begin
      errors++;
      $display("FAIL b2b_hold got v=%b d0=%h d1=%h exp v=0 d=103", rvalid[0], rd[0], rd[1]);
    end
    idle();
  endtask

  task automatic test_bank_indep();
    wr(10'd8, 32'h1, 32'hFFFF_FFFF);
    rdq(10'd8);
    rdq(10'd9);
    checks++;
    if (rd[0] !== 32'h1) begin
      errors++;
      $display("FAIL raw_addr8 got %h exp 00000001", rd[0]);
    end
    idle();
    checks++;
    if (rd[0] !== IV) begin
      errors++;
      $display("FAIL untouched_addr9 got %h exp %h", rd[0], IV);
    end
    repeat (2) idle();
  endtask

  task automatic test_reset_mid();
    int r;
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    repeat (100) idle();
    checks++;
    if (done[0] !== 1'b0) begin
      errors++;
      $display("FAIL midfill_done got %b exp 0", done[0]);
    end
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    r = lre;
    for (int i = 0; i < 400; i++) begin
      idle();
      if (done[0]) break;
    end
    checks++;
    if (cyc - r != 256) begin
      errors++;
      $display("FAIL refill_len got %0d exp 256", cyc - r);
    end
    wait_all_done();
    wr(10'd5, 32'h5555_0000, 32'hFFFF_FFFF);
    rdq(10'd5);
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (rvalid[0] !== 1'b1 || rd[0] !== 32'h5555_0000) begin
      errors++;
      $display("FAIL pre_reset_rsp got v=%b d=%h exp v=1 d=55550000", rvalid[0], rd[0]);
    end
    idle();
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (rvalid[k] !== 1'b0 || rd[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_drop cfg%0d got v=%b d=%h exp v=0 d=0", k, rvalid[k], rd[k]);
      end
    end
    idle();
    checks++;
    if (rvalid !== '0) begin
      errors++;
      $display("FAIL reset_no_pulse got %b exp 000", rvalid);
    end
    wait_all_done();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      logic [9:0]  a;
      logic [31:0] m;
      int          sel;
      a = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      drive(1'b0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 1) != 0, $urandom, m);
    end
    repeat (4) idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NC; k++) held[k] = '0;
    test_reset();
    test_masked_write();
    test_back_to_back();
    test_bank_indep();
    test_reset_mid();
    test_random();
    repeat (4) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
